csr_trap_ctrl: RTL
==================

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have VECTORED_EN, default 1, meaning 1 enables mtvec vectored mode for interrupts and 0 forces direct mode.
REQ-002 SHALL have IRQ_CAUSE, default 4'd11, meaning the cause code reported for irq_i (machine external interrupt).

Ports (name, direction, width, meaning):
REQ-003 SHALL have clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have exc_valid_i input 1 (synchronous exception request); exc_cause_i input 4; trap_pc_i input 30 ([31:2], PC saved to mepc).
REQ-006 SHALL have irq_i input 1 (level interrupt); mret_i input 1 (MRET in execute).
REQ-007 SHALL have csr_req_i input 1 (pipeline CSR instruction) and csr_gnt_o output 1 (CSR port granted to pipeline this cycle).
REQ-008 SHALL have mstatus_i, mtvec_i and mepc_i, all input 32: current CSR values.
REQ-009 SHALL have the CSR write port outputs: csr_we_o 1, csr_addr_o 12, csr_op_o 2 (always 2'b01 = RW when csr_we_o is 1), csr_wdata_o 32.
REQ-010 SHALL have trap_ack_o output 1 (trap or MRET accepted); busy_o output 1; redirect_o output 1; redirect_pc_o output 32; flush_o output 1.

Function
REQ-011 SHALL use the FSM states IDLE, T_EPC, T_CAUSE, T_STAT, T_REDIR, R_STAT and R_REDIR.
REQ-012 SHALL define trap_req = exc_valid_i | (irq_i & mstatus_i[3]) when in IDLE; priority is exception, then interrupt, then mret_i.
REQ-013 SHALL, on trap_req in IDLE in cycle N: assert trap_ack_o combinationally in N, latch the PC, the cause and an is_irq flag, and enter T_EPC at N+1.
REQ-014 SHALL, on mret_i with no trap_req in IDLE: assert trap_ack_o in N and enter R_STAT at N+1.
REQ-015 SHALL in T_EPC drive csr_we_o=1, csr_addr_o=12'h341, csr_wdata_o={latched PC,2'b00}.
REQ-016 SHALL in T_CAUSE drive addr 12'h342 with wdata {is_irq,27'b0,cause}, where cause is exc_cause_i or IRQ_CAUSE.
REQ-017 SHALL in T_STAT drive addr 12'h300 with wdata = mstatus_i with bit7 (MPIE) = mstatus_i[3], bit3 (MIE) = 0 and bits[12:11] (MPP) = 2'b11.
REQ-018 SHALL in T_REDIR assert redirect_o=1 and flush_o=1 for exactly one cycle, then return to IDLE.
REQ-019 SHALL in T_REDIR set redirect_pc_o = {mtvec_i[31:2],2'b00}, except when VECTORED_EN=1, mtvec_i[1:0]=2'b01 and is_irq=1, in which case it SHALL add 4*cause (wrap-around mod 2^32).
REQ-020 SHALL in R_STAT write 12'h300 with MIE = mstatus_i[7], MPIE = 1, MPP = 2'b11, all other bits unchanged.
REQ-021 SHALL in R_REDIR assert redirect_o and flush_o with redirect_pc_o = {mepc_i[31:2],2'b00}, then return to IDLE.
REQ-022 SHALL produce the trap latency: accept at N, CSR writes in N+1..N+3, redirect at N+4; MRET: write at N+1, redirect at N+2.
REQ-023 SHALL drive busy_o = (state != IDLE).
REQ-024 SHALL drive csr_gnt_o = csr_req_i & IDLE & ~trap_req & ~mret_i, so the pipeline CSR access is stalled whenever a trap or MRET is accepted.
REQ-025 SHALL ignore all requests while busy_o=1; an irq_i still pending, with MIE re-enabled, SHALL be taken from IDLE.
REQ-026 SHALL drive csr_we_o, redirect_o and flush_o to 0, and csr_addr_o, csr_wdata_o and redirect_pc_o to 0, in every cycle where the respective signal is not active.

Reset
REQ-027 SHALL, while rst_i=0, force state IDLE, all latched registers and all outputs to 0, asynchronously.
REQ-028 SHALL, on reset mid-sequence, abort the sequence with no further CSR writes or redirects, and resume in IDLE on the first edge after release.

Verification
REQ-029 SHALL cover: exc_valid_i=1, exc_cause_i=2, trap_pc_i=30'h40, mstatus_i=32'h8, mtvec_i=32'h100 -> writes 341<=0x100, 342<=0x2, 300<=0x1880; redirect_pc_o=0x100 at N+4.
REQ-030 SHALL cover: irq_i=1, mstatus_i=32'h8, mtvec_i=32'h101 -> cause 0x8000000B; redirect_pc_o=0x12C.
REQ-031 SHALL cover: irq_i=1 with mstatus_i[3]=0 -> no trap_ack_o; csr_gnt_o follows csr_req_i.
REQ-032 SHALL cover: exc_valid_i, mret_i and csr_req_i all high in the same cycle -> exception taken; csr_gnt_o=0; mret ignored.
REQ-033 SHALL cover: mret_i with mstatus_i=32'h1880 and mepc_i=32'h203 -> write 300<=0x1888; redirect_pc_o=0x200 at N+2.
REQ-034 SHALL cover: rst_i low in T_CAUSE -> all outputs 0 immediately; no T_STAT write after release.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap / MRET sequencer. Accepts a trap or MRET from IDLE,
// then steps through the CSR write port one register per cycle
// (mepc, mcause, mstatus) and ends with a single-cycle redirect+flush.
module csr_trap_ctrl #(
  parameter bit         VECTORED_EN = 1'b1,
  parameter logic [3:0] IRQ_CAUSE   = 4'd11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [29:0] trap_pc_i,
  input  logic        irq_i,
  input  logic        mret_i,
  input  logic        csr_req_i,
  output logic        csr_gnt_o,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        csr_we_o,
  output logic [11:0] csr_addr_o,
  output logic [1:0]  csr_op_o,
  output logic [31:0] csr_wdata_o,
  output logic        trap_ack_o,
  output logic        busy_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o
);

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STAT, T_REDIR, R_STAT, R_REDIR
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [3:0]  cause_q, cause_d;
  logic        irq_q, irq_d;

  logic idle, trap_req, mret_req;
  logic unused_mepc_lsbs;

  // mepc low bits are always replaced by zero on return
  assign unused_mepc_lsbs = ^mepc_i[1:0];

  assign idle     = (state_q == IDLE);
  assign trap_req = idle & (exc_valid_i | (irq_i & mstatus_i[3]));
  assign mret_req = idle & mret_i & ~trap_req;

  // State and trap-context registers; reset aborts any sequence in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      irq_q   <= irq_d;
    end
  end

  // Next state; exception beats interrupt beats MRET, nothing accepted while busy
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    irq_d   = irq_q;
    unique case (state_q)
      IDLE: begin
        if (trap_req) begin
          state_d = T_EPC;
          pc_d    = trap_pc_i;
          irq_d   = ~exc_valid_i;
          cause_d = exc_valid_i ? exc_cause_i : IRQ_CAUSE;
        end else if (mret_req) begin
          state_d = R_STAT;
        end
      end
      T_EPC:   state_d = T_CAUSE;
      T_CAUSE: state_d = T_STAT;
      T_STAT:  state_d = T_REDIR;
      T_REDIR: state_d = IDLE;
      R_STAT:  state_d = R_REDIR;
      R_REDIR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; every inactive field is held at zero, and the combinational
  // handshakes are gated by reset so everything reads 0 while in reset
  always_comb begin
    csr_we_o      = 1'b0;
    csr_addr_o    = '0;
    csr_wdata_o   = '0;
    redirect_o    = 1'b0;
    flush_o       = 1'b0;
    redirect_pc_o = '0;
    trap_ack_o    = rst_i & (trap_req | mret_req);
    csr_gnt_o     = rst_i & csr_req_i & idle & ~trap_req & ~mret_i;
    busy_o        = ~idle;
    unique case (state_q)
      T_EPC: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h341;
        csr_wdata_o = {pc_q, 2'b00};
      end
      T_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h342;
        csr_wdata_o = {irq_q, 27'b0, cause_q};
      end
      T_STAT: begin
        csr_we_o          = 1'b1;
        csr_addr_o        = 12'h300;
        csr_wdata_o       = mstatus_i;
        csr_wdata_o[7]    = mstatus_i[3];
        csr_wdata_o[3]    = 1'b0;
        csr_wdata_o[12:11] = 2'b11;
      end
      T_REDIR: begin
        redirect_o = 1'b1;
        flush_o    = 1'b1;
        if (VECTORED_EN && mtvec_i[1:0] == 2'b01 && irq_q)
          redirect_pc_o = {mtvec_i[31:2], 2'b00} + {26'b0, cause_q, 2'b00};
        else
          redirect_pc_o = {mtvec_i[31:2], 2'b00};
      end
      R_STAT: begin
        csr_we_o          = 1'b1;
        csr_addr_o        = 12'h300;
        csr_wdata_o       = mstatus_i;
        csr_wdata_o[3]    = mstatus_i[7];
        csr_wdata_o[7]    = 1'b1;
        csr_wdata_o[12:11] = 2'b11;
      end
      R_REDIR: begin
        redirect_o    = 1'b1;
        flush_o       = 1'b1;
        redirect_pc_o = {mepc_i[31:2], 2'b00};
      end
      default: ;
    endcase
    csr_op_o = csr_we_o ? 2'b01 : 2'b00;
  end

endmodule
